// File: rtl/layer_hdr_pkg.sv
// Layer header field map and scan-state encoding shared by the header,
// hit-scan and sprite/text fetch stages.
//
// Header layout (128 bits):
//   [0]       populated flag
//   [1]       sprite flag (1 = sprite, 0 = text run)
//   [2]       hidden flag
//   [31:16]   width  (sprite pixels, or font width for text)
//   [47:32]   height (sprite pixels, or font height for text)
//   [63:48]   X position, signed
//   [79:64]   Y position, signed
//   [111:96]  character count (text only)
package layer_hdr_pkg;

  localparam int HDR_W          = 128;
  localparam int FIELD_W        = 16;

  localparam int FLAG_POPULATED = 0;
  localparam int FLAG_SPRITE    = 1;
  localparam int FLAG_HIDDEN    = 2;

  localparam int WIDTH_LSB      = 16;
  localparam int HEIGHT_LSB     = 32;
  localparam int XPOS_LSB       = 48;
  localparam int YPOS_LSB       = 64;
  localparam int NCHARS_LSB     = 96;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Pulls one 16-bit field out of a header given its lsb position.
  function automatic logic [FIELD_W-1:0] hdrField(input logic [HDR_W-1:0] hdr,
                                                  input int lsb);
    return hdr[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/layer_hit_test.sv
// Combinational coverage test of one layer header against one pixel.
//
// Ports:
//   flags     in   3        populated / sprite / hidden flags
//   width     in   16       sprite width or font width
//   height    in   16       sprite height or font height
//   xPos      in   16       layer X position, signed
//   yPos      in   16       layer Y position, signed
//   nChars    in   16       character count (text layers)
//   pixelX    in   COORD_W  pixel X, unsigned
//   pixelY    in   COORD_W  pixel Y, unsigned
//   candidate out  1        layer is populated and visible
//   covers    out  1        pixel lies inside the layer rectangle
//   dx        out  16       pixelX - xPos (in-layer X offset when covering)
//   dy        out  16       pixelY - yPos (in-layer Y offset when covering)
module layer_hit_test
  import layer_hdr_pkg::*;
#(
  parameter int COORD_W = 11
) (
  input  logic [2:0]         flags,
  input  logic [15:0]        width,
  input  logic [15:0]        height,
  input  logic [15:0]        xPos,
  input  logic [15:0]        yPos,
  input  logic [15:0]        nChars,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  output logic               candidate,
  output logic               covers,
  output logic [15:0]        dx,
  output logic [15:0]        dy
);

  logic [17:0] dxFull;
  logic [17:0] dyFull;
  logic [31:0] extW;
  logic [31:0] extH;
  logic        insideX;
  logic        insideY;

  // 18-bit signed differences: the unsigned pixel coordinate is zero-extended
  // and the signed position sign-extended, so partly off-screen layers with
  // negative positions still produce correct offsets.
  assign dxFull = {{(18-COORD_W){1'b0}}, pixelX} - {{2{xPos[15]}}, xPos};
  assign dyFull = {{(18-COORD_W){1'b0}}, pixelY} - {{2{yPos[15]}}, yPos};

  // Text runs are nChars glyphs wide; the product is kept at full 32 bits so
  // long runs never wrap into a spuriously narrow extent.
  assign extW = flags[FLAG_SPRITE] ? {16'd0, width}
                                   : ({16'd0, width} * {16'd0, nChars});
  assign extH = {16'd0, height};

  // A zero extent makes the upper-bound test impossible, so empty layers and
  // text runs with no characters never cover anything.
  assign insideX = !dxFull[17] && ({15'd0, dxFull[16:0]} < extW);
  assign insideY = !dyFull[17] && ({15'd0, dyFull[16:0]} < extH);

  assign covers    = insideX && insideY;
  assign candidate = flags[FLAG_POPULATED] && !flags[FLAG_HIDDEN];
  assign dx        = dxFull[15:0];
  assign dy        = dyFull[15:0];

endmodule

// File: rtl/layer_hit_scanner.sv
// Pipeline stage 2: for each accepted pixel, walks layer headers from the
// frontmost (layer 0) backwards and reports the first populated, visible
// layer that covers the pixel, or background if none does.
//
// Ports:
//   clk          in   1        pipeline clock
//   reset        in   1        asynchronous, active-high reset
//   pixelValid   in   1        upstream presents a pixel
//   pixelReady   out  1        pixel accepted (only while idle)
//   pixelX       in   COORD_W  pixel X, unsigned
//   pixelY       in   COORD_W  pixel Y, unsigned
//   layer        out  LAYER_W  layer index driven to the header stage
//   layerHeader  in   128      header of `layer`, valid in the same cycle
//   hitValid     out  1        result valid
//   hitReady     in   1        downstream consumes result
//   hit          out  1        1 = covering layer found, 0 = background
//   hitLayer     out  LAYER_W  covering layer index (0 on miss)
//   hitHeader    out  128      covering layer's header (0 on miss)
//   offsetX      out  16       pixelX - layer X position (0 on miss)
//   offsetY      out  16       pixelY - layer Y position (0 on miss)
module layer_hit_scanner
  import layer_hdr_pkg::*;
#(
  parameter int NUM_LAYERS = 32,
  parameter int LAYER_W    = 5,
  parameter int COORD_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixelValid,
  output logic               pixelReady,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  output logic [LAYER_W-1:0] layer,
  input  logic [HDR_W-1:0]   layerHeader,
  output logic               hitValid,
  input  logic               hitReady,
  output logic               hit,
  output logic [LAYER_W-1:0] hitLayer,
  output logic [HDR_W-1:0]   hitHeader,
  output logic [15:0]        offsetX,
  output logic [15:0]        offsetY
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  scan_state_t        state;
  logic [COORD_W-1:0] pixelXLatched;
  logic [COORD_W-1:0] pixelYLatched;
  logic               candidate;
  logic               covers;
  logic [15:0]        dx;
  logic [15:0]        dy;

  // Only one pixel is ever in flight, so new pixels are taken only while idle.
  assign pixelReady = (state == IDLE);

  layer_hit_test #(
    .COORD_W (COORD_W)
  ) hitTest (
    .flags     (layerHeader[2:0]),
    .width     (hdrField(layerHeader, WIDTH_LSB)),
    .height    (hdrField(layerHeader, HEIGHT_LSB)),
    .xPos      (hdrField(layerHeader, XPOS_LSB)),
    .yPos      (hdrField(layerHeader, YPOS_LSB)),
    .nChars    (hdrField(layerHeader, NCHARS_LSB)),
    .pixelX    (pixelXLatched),
    .pixelY    (pixelYLatched),
    .candidate (candidate),
    .covers    (covers),
    .dx        (dx),
    .dy        (dy)
  );

  // Scan controller. The pixel is latched on acceptance so upstream may move
  // on immediately; each scan cycle tests the header currently presented for
  // `layer`, so headers rewritten mid-scan are seen as of their own cycle.
  // The result registers are loaded once, on leaving SCAN, and then held
  // until the downstream stage takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      layer         <= '0;
      pixelXLatched <= '0;
      pixelYLatched <= '0;
      hitValid      <= 1'b0;
      hit           <= 1'b0;
      hitLayer      <= '0;
      hitHeader     <= '0;
      offsetX       <= '0;
      offsetY       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pixelValid) begin
            pixelXLatched <= pixelX;
            pixelYLatched <= pixelY;
            layer         <= '0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (candidate && covers) begin
            hit       <= 1'b1;
            hitLayer  <= layer;
            hitHeader <= layerHeader;
            offsetX   <= dx;
            offsetY   <= dy;
            hitValid  <= 1'b1;
            state     <= DONE;
          end else if (layer == LAST_LAYER) begin
            hit       <= 1'b0;
            hitLayer  <= '0;
            hitHeader <= '0;
            offsetX   <= '0;
            offsetY   <= '0;
            hitValid  <= 1'b1;
            state     <= DONE;
          end else begin
            layer <= layer + LAYER_W'(1);
          end
        end
        DONE: begin
          if (hitReady) begin
            hitValid <= 1'b0;
            layer    <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
